// File: rtl/pwm_update_scheduler.sv
`default_nettype none
// ============================================================================
// pwm_update_scheduler: per-channel PWM generator with period-boundary config
// update (shadow registers) and latched fault shutdown. Rev 1.0
// ============================================================================
module pwm_update_scheduler #(
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  input  logic [DT_WIDTH-1:0]  cfg_dt,
  output logic                 cfg_err,
  input  logic                 fault_in,
  input  logic                 fault_clear,
  output logic                 pwm_out,
  output logic [DT_WIDTH-1:0]  dt_value,
  output logic                 period_start,
  output logic                 fault_latched,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic [CNT_WIDTH-1:0] sh_period_q, sh_period_d;
  logic [CNT_WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic [DT_WIDTH-1:0]  sh_dt_q, sh_dt_d;
  logic [DT_WIDTH-1:0]  dt_d;
  logic                 pwm_d, ps_d, err_d;

  logic accept, cfg_good, cfg_bad, at_wrap;

  assign cfg_ready     = ((state_q == IDLE) || (state_q == RUN)) && !fault_in;
  assign accept        = cfg_valid && cfg_ready;
  assign cfg_good      = accept && (cfg_period != '0);
  assign cfg_bad       = accept && (cfg_period == '0);
  assign at_wrap       = (cnt_q == (period_q - CNT_WIDTH'(1)));
  assign state         = state_q;
  assign fault_latched = (state_q == FAULT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    duty_d      = duty_q;
    dt_d        = dt_value;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    sh_dt_d     = sh_dt_q;
    pwm_d       = 1'b0;
    ps_d        = 1'b0;
    err_d       = cfg_bad;

    if (fault_in) begin
      // Fault overrides everything; active values survive so the host can resume.
      state_d     = FAULT;
      cnt_d       = '0;
      sh_period_d = '0;
      sh_duty_d   = '0;
      sh_dt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (cfg_good) begin
            period_d = cfg_period;
            duty_d   = cfg_duty;
            dt_d     = cfg_dt;
          end
          if (enable && (period_q != '0)) begin
            state_d = RUN;
          end
        end
        RUN, PENDING: begin
          pwm_d = (cnt_q < duty_q);
          ps_d  = (cnt_q == '0);
          cnt_d = at_wrap ? '0 : cnt_q + CNT_WIDTH'(1);
          if (state_q == PENDING) begin
            if (at_wrap) begin
              period_d = sh_period_q;
              duty_d   = sh_duty_q;
              dt_d     = sh_dt_q;
              state_d  = enable ? RUN : IDLE;
            end
          end else if (at_wrap && !enable) begin
            // Stopping this cycle: a config accepted now goes straight to active.
            state_d = IDLE;
            if (cfg_good) begin
              period_d = cfg_period;
              duty_d   = cfg_duty;
              dt_d     = cfg_dt;
            end
          end else if (cfg_good) begin
            sh_period_d = cfg_period;
            sh_duty_d   = cfg_duty;
            sh_dt_d     = cfg_dt;
            state_d     = PENDING;
          end
        end
        FAULT: begin
          cnt_d = '0;
          if (fault_clear) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      duty_q       <= '0;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      sh_dt_q      <= '0;
      dt_value     <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      sh_dt_q      <= sh_dt_d;
      dt_value     <= dt_d;
      pwm_out      <= pwm_d;
      period_start <= ps_d;
      cfg_err      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_update_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pwm_update_scheduler: directed scenarios plus randomized traffic checked
// every cycle against a period/queue-level model. Rev 1.0
// ============================================================================
module tb_pwm_update_scheduler;

  localparam int CW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n, enable, cfg_valid, cfg_ready;
  logic [CW-1:0] cfg_period, cfg_duty;
  logic [DW-1:0] cfg_dt, dt_value;
  logic          cfg_err, fault_in, fault_clear, pwm_out, period_start, fault_latched;
  logic [1:0]    state;

  pwm_update_scheduler #(.CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_dt(cfg_dt),
    .cfg_err(cfg_err), .fault_in(fault_in), .fault_clear(fault_clear),
    .pwm_out(pwm_out), .dt_value(dt_value), .period_start(period_start),
    .fault_latched(fault_latched), .state(state)
  );

  always #5 clk = ~clk;

  // Model: running/fault flags, position within period, queue of waiting configs.
  typedef struct {
    int per;
    int duty;
    int dt;
  } cfg_t;

  cfg_t pend[$];
  int   m_per, m_duty, m_dt, m_pos;
  bit   m_run, m_fault, m_pwm, m_ps, m_err, m_valid;
  int   checks = 0;
  int   errors = 0;

  function automatic int m_state();
    if (m_fault) return 3;
    if (!m_run) return 0;
    return (pend.size() != 0) ? 2 : 1;
  endfunction

  function automatic bit m_ready();
    return !m_fault && (!m_run || pend.size() == 0) && !fault_in;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   acc, good, last, start;
    cfg_t c;
    if (!reset_n) begin
      m_run = 0; m_fault = 0; m_pos = 0; m_per = 0; m_duty = 0; m_dt = 0;
      m_pwm = 0; m_ps = 0; m_err = 0; m_valid = 1;
      pend.delete();
      return;
    end
    acc   = cfg_valid && m_ready();
    good  = acc && (cfg_period != 0);
    c.per = int'(cfg_period); c.duty = int'(cfg_duty); c.dt = int'(cfg_dt);
    m_err = acc && (cfg_period == 0);
    if (fault_in) begin
      m_fault = 1; m_run = 0; m_pos = 0; m_pwm = 0; m_ps = 0;
      pend.delete();
      return;
    end
    if (m_fault) begin
      m_pwm = 0; m_ps = 0;
      if (fault_clear) m_fault = 0;
      return;
    end
    if (!m_run) begin
      m_pwm = 0; m_ps = 0;
      start = enable && (m_per != 0);
      if (good) begin m_per = c.per; m_duty = c.duty; m_dt = c.dt; end
      m_pos = 0;
      m_run = start;
      return;
    end
    m_pwm = (m_pos < m_duty);
    m_ps  = (m_pos == 0);
    last  = (m_pos == m_per - 1);
    m_pos = last ? 0 : m_pos + 1;
    if (pend.size() != 0) begin
      if (last) begin
        c = pend.pop_front();
        m_per = c.per; m_duty = c.duty; m_dt = c.dt;
        m_run = enable;
      end
    end else if (last && !enable) begin
      if (good) begin m_per = c.per; m_duty = c.duty; m_dt = c.dt; end
      m_run = 0;
    end else if (good) begin
      pend.push_back(c);
    end
  endtask

  task automatic compare_all();
    if (!m_valid) return;
    chk("pwm_out", pwm_out, m_pwm);
    chk("period_start", period_start, m_ps);
    chk("cfg_err", cfg_err, m_err);
    chk("dt_value", dt_value, m_dt);
    chk("state", state, m_state());
    chk("fault_latched", fault_latched, m_fault);
    chk("cfg_ready", cfg_ready, m_ready());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_cfg(input int p, input int d, input int t);
    cfg_valid = 1; cfg_period = CW'(p); cfg_duty = CW'(d); cfg_dt = DW'(t);
    tick();
    cfg_valid = 0;
  endtask

  task automatic wait_ps();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (period_start === 1'b1) ok = 1;
    end
    chk("wait_period_start", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (state === 2'd0) ok = 1;
    end
    chk("wait_idle", ok, 1);
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) tick();
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    int hi, n;
    m_valid = 0;
    reset_n = 0; enable = 0; cfg_valid = 0; cfg_period = '0; cfg_duty = '0;
    cfg_dt = '0; fault_in = 0; fault_clear = 0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_dt", dt_value, 0);
    chk("rst_ready", cfg_ready, 1);
    reset_n = 1;
    tick();

    // Basic run {10,4,2}
    send_cfg(10, 4, 2);
    chk("basic_dt", dt_value, 2);
    enable = 1;
    wait_ps();
    count_pwm(10, hi);
    chk("basic_high_cnt", hi, 4);
    tick();
    chk("basic_ps_spacing", period_start, 1);

    // Boundary update {10,7,5} mid-period
    send_cfg(10, 7, 5);
    chk("upd_state_pending", state, 2);
    chk("upd_ready_low", cfg_ready, 0);
    chk("upd_dt_old", dt_value, 2);
    wait_ps();
    chk("upd_dt_new", dt_value, 5);
    count_pwm(10, hi);
    chk("upd_high_cnt", hi, 7);

    // Duty clamps and P=1
    enable = 0; wait_idle();
    send_cfg(10, 0, 1);
    enable = 1;
    hi = 0;
    for (int i = 0; i < 25; i++) begin tick(); hi += int'(pwm_out); end
    chk("clamp_d0", hi, 0);
    enable = 0; wait_idle();
    send_cfg(10, 12, 1);
    enable = 1; wait_ps();
    count_pwm(20, hi);
    chk("clamp_d12", hi, 20);
    enable = 0; wait_idle();
    send_cfg(1, 1, 0);
    enable = 1; wait_ps();
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); n += int'(period_start); end
    chk("p1_ps_every_cycle", n, 5);

    // Illegal config while running
    send_cfg(0, 3, 9);
    chk("illegal_err", cfg_err, 1);
    chk("illegal_state", state, 1);
    chk("illegal_dt", dt_value, 0);
    tick();
    chk("illegal_err_pulse", cfg_err, 0);

    // Fault at cnt=3
    enable = 0; wait_idle();
    send_cfg(10, 4, 2);
    enable = 1; wait_ps();
    tick(); tick();
    fault_in = 1; fault_clear = 1;
    tick();
    chk("fault_latched", fault_latched, 1);
    chk("fault_pwm", pwm_out, 0);
    chk("fault_dt_kept", dt_value, 2);
    tick();
    chk("fault_clear_ignored", state, 3);
    fault_in = 0; fault_clear = 0;
    tick();
    chk("fault_hold", state, 3);
    fault_clear = 1;
    tick();
    chk("fault_exit_idle", state, 0);
    fault_clear = 0;
    tick();
    chk("restart_run", state, 1);
    tick();
    chk("restart_ps", period_start, 1);

    // Reset mid-PENDING
    send_cfg(10, 7, 5);
    chk("pre_rst_pending", state, 2);
    reset_n = 0;
    tick();
    chk("rst2_state", state, 0);
    chk("rst2_dt", dt_value, 0);
    chk("rst2_pwm", pwm_out, 0);
    chk("rst2_ps", period_start, 0);
    reset_n = 1;

    // Fault and cfg_valid together
    send_cfg(10, 4, 2);
    wait_ps();
    cfg_valid = 1; cfg_period = 16'd5; cfg_duty = 16'd5; cfg_dt = 8'd5; fault_in = 1;
    tick();
    chk("fault_vs_cfg_state", state, 3);
    chk("fault_vs_cfg_err", cfg_err, 0);
    cfg_valid = 0; fault_in = 0; fault_clear = 1;
    tick();
    fault_clear = 0;
    chk("fault_vs_cfg_dt", dt_value, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(0, 299) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      cfg_valid   = ($urandom_range(0, 5) == 0);
      cfg_period  = CW'($urandom_range(0, 12));
      cfg_duty    = CW'($urandom_range(0, 14));
      cfg_dt      = DW'($urandom_range(0, 255));
      fault_in    = ($urandom_range(0, 79) == 0);
      fault_clear = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
